// File: rtl/ram_port_ctrl_pkg.sv
// Shared configuration for the RAM port controller: default bus widths,
// response FIFO geometry and the occupancy test that gates new requests.
package ram_port_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 14;
  localparam int DEF_DATA_WIDTH = 32;

  // Response FIFO depth; pointers are a single bit and wrap modulo 2.
  localparam int RSP_FIFO_DEPTH = 2;
  localparam int RSP_CNT_W      = $clog2(RSP_FIFO_DEPTH + 1);

  typedef logic [RSP_CNT_W-1:0] rsp_cnt_t;

  // True when a new read can be accepted without ever overflowing the FIFO:
  // queued entries plus the read still in the RAM, minus the entry leaving
  // this cycle, must leave at least one free slot.
  function automatic logic rsp_room(input rsp_cnt_t cnt, input logic inflight,
                                    input logic pop);
    logic [RSP_CNT_W:0] occ;
    occ = {1'b0, cnt} + {{RSP_CNT_W{1'b0}}, inflight}
        - {{RSP_CNT_W{1'b0}}, pop};
    return occ < (RSP_CNT_W + 1)'(RSP_FIFO_DEPTH);
  endfunction

endpackage

// File: rtl/ram_port_ctrl_if.sv
// Request/response bus between a requester (master) and the RAM port
// controller (slave).
interface ram_port_ctrl_if
  import ram_port_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH/8-1:0] req_be;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/ram_port_rsp_fifo.sv
// Two-entry response FIFO. Control state is reset; the data storage is not,
// since an entry is never observed before it has been written.
module ram_port_rsp_fifo
  import ram_port_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output rsp_cnt_t              count,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] mem [RSP_FIFO_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;

  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];

  // Pointer and occupancy tracking; 1-bit pointers wrap naturally modulo 2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage, written at the tail on push.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ram_port_ctrl.sv
// Single-port RAM front end: passes address/data straight to the RAM,
// strobes byte writes on accept, and returns read data through a small
// in-order response FIFO with a fixed two-cycle latency when idle.
module ram_port_ctrl
  import ram_port_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  ram_port_ctrl_if.slave          bus,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_din,
  output logic [DATA_WIDTH/8-1:0] ram_write_en,
  input  logic [DATA_WIDTH-1:0]   ram_dout
);

  logic                  rd_inflight;
  logic                  accept;
  logic                  rd_accept;
  logic                  pop;
  logic                  fifo_empty;
  rsp_cnt_t              fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;

  assign ram_addr = bus.req_addr;
  assign ram_din  = bus.req_wdata;

  assign pop = ~fifo_empty & bus.rsp_ready;

  // Reads and writes share one ready so requests never overtake each other.
  // Nothing is accepted while reset is held, which keeps the write strobes low.
  assign bus.req_ready = reset_n & rsp_room(fifo_count, rd_inflight, pop);

  assign accept    = bus.req_valid & bus.req_ready;
  assign rd_accept = accept & ~bus.req_we;

  assign ram_write_en = (accept & bus.req_we) ? bus.req_be : '0;

  assign bus.rsp_valid = ~fifo_empty;
  assign bus.rsp_rdata = fifo_head;

  // A read accepted this cycle has its RAM data valid next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_inflight <= 1'b0;
    end else begin
      rd_inflight <= rd_accept;
    end
  end

  ram_port_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rd_inflight),
    .push_data (ram_dout),
    .pop       (pop),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .head_data (fifo_head)
  );

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Directed bench for ram_port_ctrl with a behavioural synchronous RAM
// (byte-write, one-cycle registered read).
module tb_ram_port_ctrl;

  localparam int AW = 14;
  localparam int DW = 32;

  logic            clk;
  logic            reset_n;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_din;
  logic [DW/8-1:0] ram_write_en;
  logic [DW-1:0]   ram_dout;

  int checks;
  int errors;

  ram_port_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_write_en (ram_write_en),
    .ram_dout     (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  always_ff @(posedge clk) begin
    for (int b = 0; b < DW/8; b++) begin
      if (ram_write_en[b]) ram_mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
    end
    ram_dout <= ram_mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_be    = '0;
  endtask

  task automatic drive_read(input logic [AW-1:0] a);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = a;
    bus.req_be    = 4'hF;
    bus.req_wdata = '0;
  endtask

  // One write cycle: accepted immediately, strobes equal the byte enables.
  task automatic do_write(input string tag, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [3:0] be);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = a;
    bus.req_be    = be;
    bus.req_wdata = d;
    mid();
    check({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
    check({tag, "_we"}, {28'd0, ram_write_en}, {28'd0, be});
    tick();
  endtask

  // Read with rsp_ready high: no response at T and T+1, data at T+2.
  task automatic read_expect(input string tag, input logic [AW-1:0] a,
                             input logic [DW-1:0] exp);
    bus.rsp_ready = 1'b1;
    drive_read(a);
    mid();
    check({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
    check({tag, "_we0"}, {28'd0, ram_write_en}, 32'd0);
    tick();
    drive_idle();
    mid();
    check({tag, "_v_t1"}, {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    mid();
    check({tag, "_v_t2"}, {31'd0, bus.rsp_valid}, 32'd1);
    check({tag, "_data"}, bus.rsp_rdata, exp);
    tick();
    mid();
    check({tag, "_v_t3"}, {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n       = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    // Request a write while in reset: strobes must stay low
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_be    = 4'hF;
    tick();
    tick();
    mid();
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_write_en", {28'd0, ram_write_en}, 32'd0);
    tick();
    drive_idle();
    reset_n = 1'b1;
    tick();

    // Full-word write then read back
    do_write("w10", 14'h10, 32'hDEADBEEF, 4'hF);
    read_expect("r10", 14'h10, 32'hDEADBEEF);

    // Partial byte-enable write merges with existing word
    do_write("w30a", 14'h30, 32'h11223344, 4'hF);
    do_write("w30b", 14'h30, 32'h0000AB00, 4'h2);
    read_expect("r30", 14'h30, 32'h1122AB44);

    // Read immediately after a write to the same address
    do_write("w20", 14'h20, 32'hCAFEF00D, 4'hF);
    read_expect("r20", 14'h20, 32'hCAFEF00D);

    // Back-to-back reads with rsp_ready high
    for (int i = 0; i < 8; i++) do_write("wfill", 14'h40 + 14'(i), 32'hA0000000 + 32'(i), 4'hF);
    drive_idle();
    tick();
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) drive_read(14'h40 + 14'(c));
      else drive_idle();
      mid();
      if (c < 8) check("b2b_ready", {31'd0, bus.req_ready}, 32'd1);
      if (c >= 2) begin
        check("b2b_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("b2b_data", bus.rsp_rdata, 32'hA0000000 + 32'(c - 2));
      end else begin
        check("b2b_nv", {31'd0, bus.rsp_valid}, 32'd0);
      end
      tick();
    end
    mid();
    check("b2b_drained", {31'd0, bus.rsp_valid}, 32'd0);
    tick();

    // Back-pressure: only two reads fit while rsp_ready is low
    do_write("w50", 14'h50, 32'hB0B0B0B0, 4'hF);
    do_write("w51", 14'h51, 32'hB1B1B1B1, 4'hF);
    bus.rsp_ready = 1'b0;
    drive_read(14'h50);
    mid();
    check("bp_ready0", {31'd0, bus.req_ready}, 32'd1);
    tick();
    drive_read(14'h51);
    mid();
    check("bp_ready1", {31'd0, bus.req_ready}, 32'd1);
    tick();
    drive_read(14'h52);
    for (int c = 0; c < 3; c++) begin
      mid();
      check("bp_blocked", {31'd0, bus.req_ready}, 32'd0);
      check("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("bp_stable", bus.rsp_rdata, 32'hB0B0B0B0);
      tick();
    end
    drive_idle();
    bus.rsp_ready = 1'b1;
    mid();
    check("bp_head0", bus.rsp_rdata, 32'hB0B0B0B0);
    tick();
    mid();
    check("bp_v1", {31'd0, bus.rsp_valid}, 32'd1);
    check("bp_head1", bus.rsp_rdata, 32'hB1B1B1B1);
    tick();
    mid();
    check("bp_empty", {31'd0, bus.rsp_valid}, 32'd0);
    tick();

    // Reset one cycle after a read is accepted: the read vanishes
    bus.rsp_ready = 1'b1;
    drive_read(14'h10);
    mid();
    check("rr_ready", {31'd0, bus.req_ready}, 32'd1);
    tick();
    drive_idle();
    reset_n = 1'b0;
    mid();
    check("rr_v_in_rst", {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      mid();
      check("rr_no_stale", {31'd0, bus.rsp_valid}, 32'd0);
      tick();
    end
    read_expect("rr_after", 14'h10, 32'hDEADBEEF);

    // Reset with a response queued and stalled
    bus.rsp_ready = 1'b0;
    drive_read(14'h20);
    tick();
    drive_idle();
    tick();
    mid();
    check("rq_queued", {31'd0, bus.rsp_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rq_cleared", {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      mid();
      check("rq_no_stale", {31'd0, bus.rsp_valid}, 32'd0);
      tick();
    end
    read_expect("rq_after", 14'h51, 32'hB1B1B1B1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_ctrl.md
RAM_PORT_CTRL -- requirements
Module: ram_port_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, word address width of the attached RAM.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, RAM data width, a multiple of 8.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1 bit: request present.
REQ-006 SHALL have port req_ready, output, 1 bit: request accepted when high together with req_valid.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port req_addr, input, ADDR_WIDTH bits: word address.
REQ-009 SHALL have port req_be, input, DATA_WIDTH/8 bits: byte enables, used on writes only.
REQ-010 SHALL have port req_wdata, input, DATA_WIDTH bits: write data.
REQ-011 SHALL have port rsp_valid, output, 1 bit: read data available.
REQ-012 SHALL have port rsp_ready, input, 1 bit: consumer takes the response.
REQ-013 SHALL have port rsp_rdata, output, DATA_WIDTH bits: read data.
REQ-014 SHALL have port ram_addr, output, ADDR_WIDTH bits: RAM address.
REQ-015 SHALL have port ram_din, output, DATA_WIDTH bits: RAM write data.
REQ-016 SHALL have port ram_write_en, output, DATA_WIDTH/8 bits: per-byte RAM write strobes.
REQ-017 SHALL have port ram_dout, input, DATA_WIDTH bits: RAM read data, valid one cycle after the address is presented.

Function
REQ-018 SHALL drive ram_addr = req_addr and ram_din = req_wdata combinationally.
REQ-019 SHALL drive ram_write_en = req_be only in a cycle where req_valid, req_ready and req_we are all high; otherwise all zeros.
REQ-020 SHALL complete a write in its accept cycle and SHALL produce no response for it.
REQ-021 SHALL set a single-bit rd_inflight flag when a read is accepted in cycle T, and capture ram_dout into the response FIFO at the end of T+1.
REQ-022 SHALL therefore present rsp_valid no earlier than cycle T+2 (fixed read latency 2 when the FIFO is empty).
REQ-023 SHALL hold responses in a 2-entry FIFO with rsp_valid = not empty and rsp_rdata = head entry; responses SHALL be returned in request order.
REQ-024 SHALL assert req_ready for a read only if (fifo_count + rd_inflight - pop) < 2, where pop = rsp_valid & rsp_ready; this gives 1 read/cycle throughput while rsp_ready stays high.
REQ-025 SHALL assert req_ready for a write whenever the read condition holds, so request order is preserved; req_ready SHALL NOT depend on req_valid.
REQ-026 SHALL push and pop in the same cycle without a change in count; it SHALL NOT push when full, which REQ-024 guarantees.
REQ-027 SHALL wrap the FIFO read and write pointers modulo 2.
REQ-028 SHALL let a read accepted in the cycle after a write to the same address return the new data.
REQ-029 SHALL keep rsp_rdata stable while rsp_valid is high and rsp_ready is low.

Reset
REQ-030 SHALL, when reset_n is low, immediately clear rd_inflight, the FIFO count and both pointers; rsp_valid SHALL be 0 and ram_write_en SHALL be 0.
REQ-031 SHALL discard any in-flight read or queued response on reset mid-operation; no stale response SHALL appear after reset is released.
REQ-032 SHALL leave FIFO data storage unreset.

Structure
REQ-033 SHALL place the default ADDR_WIDTH/DATA_WIDTH constants and the FIFO depth (2) in the shared config header.
REQ-034 SHALL implement the response FIFO as one sub-module, ram_port_rsp_fifo, with the RAM interface logic at top level.

Verification
REQ-035 SHALL be verified by: write addr 0x10 data 0xDEADBEEF with be 0xF, then read 0x10 -> rsp_valid at T+2, rdata 0xDEADBEEF.
REQ-036 SHALL be verified by: be 0x2 write of 0x0000AB00 over 0x11223344 -> subsequent read returns 0x1122AB44.
REQ-037 SHALL be verified by: 8 back-to-back reads with rsp_ready held high -> req_ready stays 1 and 8 responses arrive on consecutive cycles, in order.
REQ-038 SHALL be verified by: rsp_ready held low while reads are issued -> exactly 2 reads are accepted and req_ready drops to 0; releasing rsp_ready drains both in order with rdata held stable while stalled.
REQ-039 SHALL be verified by: reset_n pulsed low one cycle after a read is accepted -> no rsp_valid ever appears for that read; a read issued after reset returns correctly.
REQ-040 SHALL be verified by: a write to 0x20 followed in the next cycle by a read of 0x20 -> the read returns the newly written value.
